fdsti_sched_table: RTL and testbench
====================================

# fdsti_sched_table

Entry table and issue stage on the source side of the FDSTI minimum-compare tree. It stores up to N_ENTRY pending entries, each an FDSTI timestamp plus an FDSSI identifier. It drives the per-entry valid/wt/FDSTI/FDSSI vectors into the tree and takes the tree's winner (smallest FDSTI among valid, non-waiting entries) back. It then issues that winner downstream over a valid/ready handshake and frees the entry once the handshake completes.

## Interface
- N_ENTRY, 8, number of table entries (power of two, ≥2)
- I_FDSTI_WIDTH, 28, FDSTI timestamp width
- I_FDSSI_WIDTH, 12, FDSSI identifier width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  write a new entry
- wr_fdsti  in  I_FDSTI_WIDTH  timestamp of new entry
- wr_fdssi  in  I_FDSSI_WIDTH  identifier of new entry
- wr_wt  in  1  new entry starts in wait state (ineligible)
- rel_en  in  1  release wait on an entry
- rel_fdssi  in  I_FDSSI_WIDTH  identifier to release
- valid  out  N_ENTRY  per-entry occupied flag, to tree
- wt  out  N_ENTRY  per-entry wait flag, to tree
- FDSTI  out  I_FDSTI_WIDTH*N_ENTRY  flattened timestamps; entry i at [i*W +: W]
- FDSSI  out  I_FDSSI_WIDTH*N_ENTRY  flattened identifiers, same packing
- tree_valid  in  1  tree winner valid (combinational from valid/wt/FDSTI)
- tree_fdsti  in  I_FDSTI_WIDTH  winner timestamp
- tree_fdssi  in  I_FDSSI_WIDTH  winner identifier
- iss_valid  out  1  issue output valid
- iss_ready  in  1  downstream accepts issue
- iss_fdsti  out  I_FDSTI_WIDTH  issued timestamp
- iss_fdssi  out  I_FDSSI_WIDTH  issued identifier
- full  out  1  all entries occupied
- count  out  $clog2(N_ENTRY)+1  occupied entries
- err_ovf  out  1  one-cycle pulse: write dropped because full
- err_dup  out  1  one-cycle pulse: write dropped because FDSSI is already present

## Operation
- Per entry: registers v, w, inflight, fdsti, fdssi. valid=v and FDSTI/FDSSI are driven from registers. wt[i] = w[i] | inflight[i], so an in-flight entry is never reselected.
- Write: if wr_en and !full and no valid entry has fdssi==wr_fdssi, allocate the lowest-index free entry. Set v=1, w=wr_wt, inflight=0. Full and duplicate checks use registered state only; an entry freed in the same cycle is not reusable until the next cycle.
- Write while full: drop it and pulse err_ovf. Duplicate FDSSI: drop it and pulse err_dup. If both apply, only err_ovf pulses.
- Release: if rel_en matches a valid, non-inflight entry, clear w. Otherwise ignore it. A release of the same FDSSI in the same cycle as its write is ignored.
- State machine, 2 states:
  - IDLE: iss_valid=0. If tree_valid, capture tree_fdsti/tree_fdssi into the issue registers, set inflight on the entry whose fdssi==tree_fdssi, and go to HOLD.
  - HOLD: iss_valid=1. The issue registers stay stable. On iss_valid&iss_ready, clear v/w/inflight of the in-flight entry and go to IDLE.
- FDSSI values are unique among valid entries, so the winner-to-entry match is one-hot. If no entry matches (illegal tree output), do not capture and stay in IDLE.
- count = popcount(v); full = (count==N_ENTRY).

## Timing
- Reset (async assert, sync release) clears all v/w/inflight/fdsti/fdssi, sets state IDLE, and sets iss_valid=0, iss_fdsti=0, iss_fdssi=0, full=0, count=0, err_ovf=0, err_dup=0.
- A write in cycle t is visible on valid/wt and count in t+1. With wr_wt=0 in IDLE, earliest capture is t+1 and iss_valid is high at t+2.
- Capture at edge t puts iss_valid high from t+1. A handshake at edge t+k frees the entry at t+k+1 (count decrements) and returns the state to IDLE. The next capture is at edge t+k+1, so peak throughput is one issue per 2 cycles.
- iss_valid never drops without iss_ready, and iss_fdsti/iss_fdssi never change in HOLD.
- Reset asserted mid-HOLD immediately drops iss_valid and discards the in-flight entry.
- A write and a handshake in the same cycle both take effect. The freed slot is allocatable from the next cycle.

## Test plan
- Reset, then write FDSSI 5/FDSTI 100 (wr_wt=0), with iss_ready=1 -> iss_valid at +2 cycles with 100/5; count 1→0 one cycle after the handshake.
- Write FDSTI 300/200/250 (ids 1/2/3, wr_wt=0), iss_ready held high -> issue order ids 2,3,1; one issue every 2 cycles.
- Write id 7 with wr_wt=1 and id 8 (FDSTI larger) with wr_wt=0 -> id 8 issues. Then rel_en id 7 -> id 7 issues. A release of an absent id has no effect.
- Fill 8 entries, then write a 9th -> full=1, err_ovf pulses, count stays 8. Write an existing id when not full -> err_dup pulses.
- Hold iss_ready=0 for 10 cycles while writing a smaller FDSTI -> the issue registers stay unchanged. Then release ready -> the newer smaller entry issues next.
- Assert rst_n low in HOLD -> iss_valid=0 and count=0 immediately; after release, the table is empty.

Source files
------------

// File: rtl/fdsti_sched_table.sv
// Entry table and issue stage feeding the FDSTI minimum-compare tree.
// Holds pending FDSTI/FDSSI entries and issues the tree winner over valid/ready.
module fdsti_sched_table #(
  parameter int N_ENTRY       = 8,
  parameter int I_FDSTI_WIDTH = 28,
  parameter int I_FDSSI_WIDTH = 12
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [I_FDSTI_WIDTH-1:0]           wr_fdsti,
  input  logic [I_FDSSI_WIDTH-1:0]           wr_fdssi,
  input  logic                               wr_wt,
  input  logic                               rel_en,
  input  logic [I_FDSSI_WIDTH-1:0]           rel_fdssi,
  output logic [N_ENTRY-1:0]                 valid,
  output logic [N_ENTRY-1:0]                 wt,
  output logic [I_FDSTI_WIDTH*N_ENTRY-1:0]   FDSTI,
  output logic [I_FDSSI_WIDTH*N_ENTRY-1:0]   FDSSI,
  input  logic                               tree_valid,
  input  logic [I_FDSTI_WIDTH-1:0]           tree_fdsti,
  input  logic [I_FDSSI_WIDTH-1:0]           tree_fdssi,
  output logic                               iss_valid,
  input  logic                               iss_ready,
  output logic [I_FDSTI_WIDTH-1:0]           iss_fdsti,
  output logic [I_FDSSI_WIDTH-1:0]           iss_fdssi,
  output logic                               full,
  output logic [$clog2(N_ENTRY):0]           count,
  output logic                               err_ovf,
  output logic                               err_dup
);

  localparam int CW = $clog2(N_ENTRY) + 1;
  localparam int TW = I_FDSTI_WIDTH;
  localparam int SW = I_FDSSI_WIDTH;
  localparam logic [N_ENTRY-1:0] ONE_HOT0 = {{(N_ENTRY-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, HOLD} state_t;

  logic [N_ENTRY-1:0] v_q, v_d;
  logic [N_ENTRY-1:0] w_q, w_d;
  logic [N_ENTRY-1:0] inf_q, inf_d;
  logic [TW-1:0]      fdsti_q [N_ENTRY];
  logic [TW-1:0]      fdsti_d [N_ENTRY];
  logic [SW-1:0]      fdssi_q [N_ENTRY];
  logic [SW-1:0]      fdssi_d [N_ENTRY];

  state_t             state_q;
  logic               issValid_q;
  logic [TW-1:0]      issFdsti_q;
  logic [SW-1:0]      issFdssi_q;
  logic               errOvf_q;
  logic               errDup_q;

  logic [N_ENTRY-1:0] dupHit;
  logic [N_ENTRY-1:0] relHit;
  logic [N_ENTRY-1:0] winHit;
  logic [N_ENTRY-1:0] allocOh;
  logic [CW-1:0]      occupancy;
  logic               isFull;
  logic               doWrite;
  logic               doCapture;
  logic               doRetire;

  // Identifier matches against registered entry state only.
  always_comb begin
    dupHit = '0;
    relHit = '0;
    winHit = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      dupHit[i] = v_q[i] && (fdssi_q[i] == wr_fdssi);
      relHit[i] = rel_en && v_q[i] && !inf_q[i] && (fdssi_q[i] == rel_fdssi);
      winHit[i] = v_q[i] && (fdssi_q[i] == tree_fdssi);
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      occupancy = occupancy + CW'(v_q[i]);
    end
  end

  // Lowest clear bit of v_q; all-zero when the table is full.
  assign allocOh   = ~v_q & (v_q + ONE_HOT0);
  assign isFull    = (occupancy == CW'(N_ENTRY));
  assign doWrite   = wr_en && !isFull && !(|dupHit);
  assign doCapture = (state_q == IDLE) && tree_valid && (|winHit);
  assign doRetire  = (state_q == HOLD) && iss_ready;

  always_comb begin
    v_d     = v_q;
    w_d     = w_q;
    inf_d   = inf_q;
    fdsti_d = fdsti_q;
    fdssi_d = fdssi_q;
    if (doRetire) begin
      v_d   = v_q & ~inf_q;
      w_d   = w_q & ~inf_q;
      inf_d = '0;
    end
    w_d = w_d & ~relHit;
    if (doCapture) begin
      inf_d = inf_d | winHit;
    end
    if (doWrite) begin
      for (int i = 0; i < N_ENTRY; i++) begin
        if (allocOh[i]) begin
          v_d[i]     = 1'b1;
          w_d[i]     = wr_wt;
          inf_d[i]   = 1'b0;
          fdsti_d[i] = wr_fdsti;
          fdssi_d[i] = wr_fdssi;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      w_q      <= '0;
      inf_q    <= '0;
      errOvf_q <= 1'b0;
      errDup_q <= 1'b0;
      for (int i = 0; i < N_ENTRY; i++) begin
        fdsti_q[i] <= '0;
        fdssi_q[i] <= '0;
      end
    end else begin
      v_q      <= v_d;
      w_q      <= w_d;
      inf_q    <= inf_d;
      errOvf_q <= wr_en && isFull;
      errDup_q <= wr_en && !isFull && (|dupHit);
      for (int i = 0; i < N_ENTRY; i++) begin
        fdsti_q[i] <= fdsti_d[i];
        fdssi_q[i] <= fdssi_d[i];
      end
    end
  end

  // Issue FSM: the issue registers only load on capture, so they are frozen in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issValid_q <= 1'b0;
      issFdsti_q <= '0;
      issFdssi_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (doCapture) begin
            issFdsti_q <= tree_fdsti;
            issFdssi_q <= tree_fdssi;
            issValid_q <= 1'b1;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (iss_ready) begin
            issValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          issValid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    FDSTI = '0;
    FDSSI = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      FDSTI[i*TW +: TW] = fdsti_q[i];
      FDSSI[i*SW +: SW] = fdssi_q[i];
    end
  end

  assign valid     = v_q;
  assign wt        = w_q | inf_q;
  assign iss_valid = issValid_q;
  assign iss_fdsti = issFdsti_q;
  assign iss_fdssi = issFdssi_q;
  assign full      = isFull;
  assign count     = occupancy;
  assign err_ovf   = errOvf_q;
  assign err_dup   = errDup_q;

endmodule

// File: tb/tb_fdsti_sched_table.sv
// Directed bench for fdsti_sched_table with a behavioural min-compare tree
// closing the loop from valid/wt/FDSTI back to tree_valid/tree_fdsti/tree_fdssi.
module tb_fdsti_sched_table;

  localparam int N  = 8;
  localparam int TW = 28;
  localparam int SW = 12;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [TW-1:0]     wr_fdsti;
  logic [SW-1:0]     wr_fdssi;
  logic              wr_wt;
  logic              rel_en;
  logic [SW-1:0]     rel_fdssi;
  logic [N-1:0]      valid;
  logic [N-1:0]      wt;
  logic [TW*N-1:0]   FDSTI;
  logic [SW*N-1:0]   FDSSI;
  logic              tree_valid;
  logic [TW-1:0]     tree_fdsti;
  logic [SW-1:0]     tree_fdssi;
  logic              iss_valid;
  logic              iss_ready;
  logic [TW-1:0]     iss_fdsti;
  logic [SW-1:0]     iss_fdssi;
  logic              full;
  logic [3:0]        count;
  logic              err_ovf;
  logic              err_dup;

  int passCount   = 0;
  int totalChecks = 0;
  int cycleCnt    = 0;

  fdsti_sched_table #(.N_ENTRY(N), .I_FDSTI_WIDTH(TW), .I_FDSSI_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_fdsti(wr_fdsti), .wr_fdssi(wr_fdssi), .wr_wt(wr_wt),
    .rel_en(rel_en), .rel_fdssi(rel_fdssi),
    .valid(valid), .wt(wt), .FDSTI(FDSTI), .FDSSI(FDSSI),
    .tree_valid(tree_valid), .tree_fdsti(tree_fdsti), .tree_fdssi(tree_fdssi),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_fdsti(iss_fdsti), .iss_fdssi(iss_fdssi),
    .full(full), .count(count), .err_ovf(err_ovf), .err_dup(err_dup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference tree: smallest FDSTI among valid, non-waiting entries, lowest index on ties.
  always_comb begin
    tree_valid = 1'b0;
    tree_fdsti = '0;
    tree_fdssi = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && !wt[i] && (!tree_valid || (FDSTI[i*TW +: TW] < tree_fdsti))) begin
        tree_valid = 1'b1;
        tree_fdsti = FDSTI[i*TW +: TW];
        tree_fdssi = FDSSI[i*SW +: SW];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int id, input int ts, input logic waitFlag);
    wr_en    = 1'b1;
    wr_fdssi = SW'(id);
    wr_fdsti = TW'(ts);
    wr_wt    = waitFlag;
    tick();
    wr_en    = 1'b0;
  endtask

  // Waits (bounded) for iss_valid, checks the payload and lets one handshake edge pass.
  task automatic waitIssue(input string tag, input int ts, input int id, output int cyc);
    int n = 0;
    while (!iss_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " valid"}, 64'(iss_valid), 64'd1);
    checkOutput({tag, " fdsti"}, 64'(iss_fdsti), 64'(ts));
    checkOutput({tag, " fdssi"}, 64'(iss_fdssi), 64'(id));
    cyc = cycleCnt;
    tick();
  endtask

  initial begin
    int c0, c1, c2, c3;
    rst_n = 1'b0; wr_en = 1'b0; wr_fdsti = '0; wr_fdssi = '0; wr_wt = 1'b0;
    rel_en = 1'b0; rel_fdssi = '0; iss_ready = 1'b0;
    tick(); tick();
    checkOutput("rst iss_valid", 64'(iss_valid), 64'd0);
    checkOutput("rst count", 64'(count), 64'd0);
    checkOutput("rst full", 64'(full), 64'd0);
    checkOutput("rst errs", 64'({err_ovf, err_dup}), 64'd0);
    checkOutput("rst valid", 64'(valid), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single entry latency");
    iss_ready = 1'b1;
    applyStimulus(5, 100, 1'b0);
    checkOutput("t1 count after write", 64'(count), 64'd1);
    checkOutput("t1 valid vec", 64'(valid), 64'h01);
    checkOutput("t1 no issue at +1", 64'(iss_valid), 64'd0);
    tick();
    checkOutput("t1 issue at +2", 64'(iss_valid), 64'd1);
    checkOutput("t1 fdsti", 64'(iss_fdsti), 64'd100);
    checkOutput("t1 fdssi", 64'(iss_fdssi), 64'd5);
    checkOutput("t1 count before hs", 64'(count), 64'd1);
    tick();
    checkOutput("t1 iss_valid after hs", 64'(iss_valid), 64'd0);
    checkOutput("t1 count after hs", 64'(count), 64'd0);

    $display("[TB] ordering and throughput");
    iss_ready = 1'b0;
    applyStimulus(9, 50, 1'b0);
    applyStimulus(1, 300, 1'b0);
    applyStimulus(2, 200, 1'b0);
    applyStimulus(3, 250, 1'b0);
    checkOutput("t2 count", 64'(count), 64'd4);
    checkOutput("t2 held id", 64'(iss_fdssi), 64'd9);
    iss_ready = 1'b1;
    waitIssue("t2 id9", 50, 9, c0);
    waitIssue("t2 id2", 200, 2, c1);
    waitIssue("t2 id3", 250, 3, c2);
    waitIssue("t2 id1", 300, 1, c3);
    checkOutput("t2 spacing 9-2", 64'(c1 - c0), 64'd2);
    checkOutput("t2 spacing 2-3", 64'(c2 - c1), 64'd2);
    checkOutput("t2 spacing 3-1", 64'(c3 - c2), 64'd2);
    checkOutput("t2 count empty", 64'(count), 64'd0);

    $display("[TB] wait and release");
    applyStimulus(7, 400, 1'b1);
    checkOutput("t3 valid vec", 64'(valid), 64'h01);
    checkOutput("t3 wt vec", 64'(wt), 64'h01);
    checkOutput("t3 FDSTI slot0", 64'(FDSTI[TW-1:0]), 64'd400);
    applyStimulus(8, 500, 1'b0);
    checkOutput("t3 valid vec2", 64'(valid), 64'h03);
    checkOutput("t3 FDSSI slot1", 64'(FDSSI[2*SW-1:SW]), 64'd8);
    waitIssue("t3 id8", 500, 8, c0);
    tick();
    checkOutput("t3 waiting not issued", 64'(iss_valid), 64'd0);
    checkOutput("t3 count", 64'(count), 64'd1);
    rel_en = 1'b1; rel_fdssi = 12'd33;
    tick();
    rel_en = 1'b0;
    tick();
    checkOutput("t3 absent release wt", 64'(wt), 64'h01);
    checkOutput("t3 absent release issue", 64'(iss_valid), 64'd0);
    rel_en = 1'b1; rel_fdssi = 12'd7;
    tick();
    rel_en = 1'b0;
    checkOutput("t3 released wt", 64'(wt), 64'h00);
    waitIssue("t3 id7", 400, 7, c0);
    checkOutput("t3 count empty", 64'(count), 64'd0);

    $display("[TB] overflow and duplicate");
    iss_ready = 1'b0;
    for (int k = 0; k < 8; k++) applyStimulus(10 + k, 1000 + k, 1'b0);
    checkOutput("t4 count full", 64'(count), 64'd8);
    checkOutput("t4 full", 64'(full), 64'd1);
    checkOutput("t4 valid vec", 64'(valid), 64'hFF);
    checkOutput("t4 held id10", 64'(iss_fdssi), 64'd10);
    applyStimulus(20, 2000, 1'b0);
    checkOutput("t4 err_ovf", 64'(err_ovf), 64'd1);
    checkOutput("t4 no err_dup", 64'(err_dup), 64'd0);
    checkOutput("t4 count stays", 64'(count), 64'd8);
    applyStimulus(13, 2000, 1'b0);
    checkOutput("t4 both ovf", 64'(err_ovf), 64'd1);
    checkOutput("t4 both no dup", 64'(err_dup), 64'd0);
    tick();
    checkOutput("t4 ovf pulse ends", 64'(err_ovf), 64'd0);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    checkOutput("t4 count after hs", 64'(count), 64'd7);
    checkOutput("t4 not full", 64'(full), 64'd0);
    applyStimulus(12, 3000, 1'b0);
    checkOutput("t4 err_dup", 64'(err_dup), 64'd1);
    checkOutput("t4 dup no ovf", 64'(err_ovf), 64'd0);
    checkOutput("t4 dup count", 64'(count), 64'd7);
    checkOutput("t4 held id11", 64'(iss_fdssi), 64'd11);

    $display("[TB] backpressure");
    applyStimulus(30, 5, 1'b0);
    checkOutput("t5 count", 64'(count), 64'd8);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t5 hold stable", 64'({iss_valid, iss_fdsti, iss_fdssi}),
                  64'({1'b1, 28'd1001, 12'd11}));
      tick();
    end
    iss_ready = 1'b1;
    waitIssue("t5 id11", 1001, 11, c0);
    waitIssue("t5 id30", 5, 30, c1);
    iss_ready = 1'b0;
    tick();
    checkOutput("t5 next held id12", 64'(iss_fdssi), 64'd12);

    $display("[TB] reset during hold");
    checkOutput("t6 in hold", 64'(iss_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async iss_valid", 64'(iss_valid), 64'd0);
    checkOutput("t6 async count", 64'(count), 64'd0);
    checkOutput("t6 async full", 64'(full), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t6 empty valid", 64'(valid), 64'd0);
    checkOutput("t6 empty iss", 64'({iss_valid, iss_fdsti, iss_fdssi}), 64'd0);
    iss_ready = 1'b1;
    applyStimulus(40, 77, 1'b0);
    waitIssue("t6 id40", 77, 40, c0);
    checkOutput("t6 count end", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
